text_console: RTL and testbench

Upstream feeder for `graphics_card`: accepts a byte stream of ASCII characters from the CPU side over a valid/ready handshake, interprets a small set of control codes, and maintains a COLS×ROWS character buffer with cursor and hardware scrolling. The graphics card reads the buffer through a synchronous logical (row, col) read port while scanning out each text cell. Scrolling uses a circular top-row pointer, so a scroll costs only one row clear, not a full copy.

---
 rtl/text_console_pkg.sv | 30 +++
 rtl/text_console_if.sv | 35 +++
 rtl/text_console_ram.sv | 28 ++
 rtl/text_console.sv | 192 +++++++++++++++++++
 tb/tb_text_console.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/text_console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : console_pkg
// Description : Shared defaults, FSM state type and control codes for the
//               text console.
// Revision    : 1.0 - initial release
// ============================================================================
package console_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } console_state_t;

    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= 8'h20) && (ch <= 8'h7E);
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_console_if.sv
`default_nettype none
// ============================================================================
// Module      : text_console_if
// Description : Character input handshake plus graphics-side read port and
//               cursor status of the text console.
// Revision    : 1.0 - initial release
// ============================================================================
interface text_console_if #(
    parameter int COLS = 80,
    parameter int ROWS = 30
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic             char_valid;
    logic [7:0]       char_data;
    logic             char_ready;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;
    logic [7:0]       rd_data;
    logic [ROW_W-1:0] cursor_row;
    logic [COL_W-1:0] cursor_col;
    logic             cursor_hit;

    modport master (
        output char_valid, char_data, rd_row, rd_col,
        input  char_ready, rd_data, cursor_row, cursor_col, cursor_hit
    );

    modport slave (
        input  char_valid, char_data, rd_row, rd_col,
        output char_ready, rd_data, cursor_row, cursor_col, cursor_hit
    );
endinterface
`default_nettype wire

// File: rtl/text_console_ram.sv
`default_nettype none
// ============================================================================
// Module      : text_ram
// Description : Simple dual-port character store, one synchronous write and
//               one registered read (read-before-write on address collision).
// Revision    : 1.0 - initial release
// ============================================================================
module text_ram #(
    parameter int DEPTH = 2400,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end
endmodule
`default_nettype wire

// File: rtl/text_console.sv
`default_nettype none
// ============================================================================
// Module      : text_console
// Description : ASCII stream to character buffer with cursor, control codes
//               and circular-row scrolling. TEXT_CONSOLE_CURSOR_EN enables
//               the registered cursor_hit compare.
// Revision    : 1.0 - initial release
// ============================================================================
module text_console
    import console_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic          clk,
    input  logic          rst,
    text_console_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [COL_W-1:0] c_LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]   c_ROWS     = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0]   c_COLS     = (COL_W + 1)'(COLS);
    localparam logic [AW-1:0]    c_COLS_A   = AW'(COLS);
    localparam logic [AW-1:0]    c_CELLS_M1 = AW'(CELLS - 1);
    localparam logic [AW-1:0]    c_COLS_M1  = AW'(COLS - 1);

    console_state_t   r_state;
    logic [AW-1:0]    r_cnt;
    logic [ROW_W-1:0] r_top, r_row, r_clr_row;
    logic [COL_W-1:0] r_col;
    logic             r_rd_oob;

    logic             w_accept, w_printable, w_line_adv, w_rd_oob;
    logic [ROW_W-1:0] w_top_next;
    logic [AW-1:0]    w_cur_addr, w_rd_addr;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [7:0]       w_wdata, w_ram_q;

    // Logical-to-physical row without a divider: both operands are < ROWS.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lr,
                                                  input logic [ROW_W-1:0] top);
        logic [ROW_W:0] s;
        s = {1'b0, lr} + {1'b0, top};
        if (s >= c_ROWS) begin
            s = s - c_ROWS;
        end
        return s[ROW_W-1:0];
    endfunction

    assign bus.char_ready = (r_state == IDLE) && rst;
    assign w_accept       = bus.char_valid && bus.char_ready;
    assign w_printable    = is_printable(bus.char_data);
    assign w_line_adv     = w_accept && ((w_printable && (r_col == c_LAST_COL)) ||
                                         (bus.char_data == CHAR_LF));
    assign w_top_next     = (r_top == c_LAST_ROW) ? '0 : r_top + 1'b1;
    assign w_cur_addr     = AW'(phys_row(r_row, r_top)) * c_COLS_A + AW'(r_col);
    assign w_rd_addr      = AW'(phys_row(bus.rd_row, r_top)) * c_COLS_A + AW'(bus.rd_col);
    assign w_rd_oob       = ({1'b0, bus.rd_row} >= c_ROWS) || ({1'b0, bus.rd_col} >= c_COLS);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_cur_addr;
        w_wdata = CHAR_SPACE;
        case (r_state)
            CLEAR_ALL: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
            end
            CLEAR_ROW: begin
                w_we    = 1'b1;
                w_waddr = AW'(r_clr_row) * c_COLS_A + r_cnt;
            end
            IDLE: begin
                if (w_accept && w_printable) begin
                    w_we    = 1'b1;
                    w_wdata = bus.char_data;
                end else if (w_accept && (bus.char_data == CHAR_BS) && (r_col != '0)) begin
                    w_we    = 1'b1;
                    w_waddr = w_cur_addr - 1'b1;
                end
            end
            default: w_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= CLEAR_ALL;
            r_cnt     <= '0;
            r_top     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_clr_row <= '0;
        end else begin
            case (r_state)
                CLEAR_ALL: begin
                    if (r_cnt == c_CELLS_M1) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CLEAR_ROW: begin
                    if (r_cnt == c_COLS_M1) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_col <= (r_col == c_LAST_COL) ? '0 : r_col + 1'b1;
                        end else if ((bus.char_data == CHAR_LF) || (bus.char_data == CHAR_CR)) begin
                            r_col <= '0;
                        end else if ((bus.char_data == CHAR_BS) && (r_col != '0)) begin
                            r_col <= r_col - 1'b1;
                        end else if (bus.char_data == CHAR_FF) begin
                            r_state <= CLEAR_ALL;
                            r_cnt   <= '0;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_top   <= '0;
                        end
                        // Scrolling recycles the old top row as the new bottom line.
                        if (w_line_adv) begin
                            if (r_row == c_LAST_ROW) begin
                                r_top     <= w_top_next;
                                r_clr_row <= r_top;
                                r_state   <= CLEAR_ROW;
                                r_cnt     <= '0;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= CLEAR_ALL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_oob <= 1'b1;
        end else begin
            r_rd_oob <= w_rd_oob;
        end
    end

    text_ram #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (w_rd_addr),
        .rdata (w_ram_q)
    );

    assign bus.rd_data    = r_rd_oob ? CHAR_SPACE : w_ram_q;
    assign bus.cursor_row = r_row;
    assign bus.cursor_col = r_col;

`ifdef TEXT_CONSOLE_CURSOR_EN
    logic r_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= (bus.rd_row == r_row) && (bus.rd_col == r_col);
        end
    end

    assign bus.cursor_hit = r_hit;
`else
    assign bus.cursor_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_text_console.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_console
// Description : Directed self-checking bench for text_console with a read
//               scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_console;
    import console_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
`ifdef TEXT_CONSOLE_CURSOR_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       hit;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_row = 0;
    int   m_col = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    text_console_if #(.COLS(COLS), .ROWS(ROWS)) bus();

    text_console #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, " cursor_row"}, 32'(bus.cursor_row), 32'(m_row));
        chk({tag, " cursor_col"}, 32'(bus.cursor_col), 32'(m_col));
    endtask

    function automatic logic hit_model(input int r, input int c);
        return HIT_EN && (r == m_row) && (c == m_col);
    endfunction

    // Called at a negedge: issue a read, expect result one clock later.
    task automatic rd_check(input int r, input int c, input logic [7:0] exp, input string tag);
        exp_t e;
        bus.rd_row = ROW_W'(r);
        bus.rd_col = COL_W'(c);
        e.data = exp;
        e.hit  = hit_model(r, c);
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, " rd_data"}, 32'(bus.rd_data), 32'(e.data));
        chk({tag, " cursor_hit"}, 32'(bus.cursor_hit), 32'(e.hit));
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.char_valid = 1'b1;
        bus.char_data  = b;
        while (!bus.char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            n_assert++;
            n_fail++;
            $error("FAIL send_timeout observed=%0d expected=<5000", n);
        end
        @(negedge clk);
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int   n;
        exp_t e;

        bus.char_valid = 1'b1;
        bus.char_data  = 8'h41;
        bus.rd_row     = '0;
        bus.rd_col     = '0;
        repeat (3) @(negedge clk);

        chk("reset char_ready", 32'(bus.char_ready), 32'd0);
        chk("reset rd_data", 32'(bus.rd_data), 32'h20);
        chk("reset cursor_hit", 32'(bus.cursor_hit), 32'd0);
        chk_cursor("reset");

        // Power-up clear with a byte already waiting.
        rst = 1'b1;
        wait_ready(n);
        chk("init clear length", 32'(n), 32'd2400);
        @(negedge clk);
        bus.char_valid = 1'b0;
        m_col = 1;
        chk_cursor("first accept");
        rd_check(0, 0, 8'h41, "first char");
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r != 0 || c != 0) rd_check(r, c, 8'h20, "init blank");
            end
        end

        // Carriage return overwrite and backspace.
        send(CHAR_CR);
        send("A");
        send("B");
        send(CHAR_CR);
        send("C");
        m_col = 1;
        chk_cursor("cr overwrite");
        rd_check(0, 0, "C", "cr cell0");
        rd_check(0, 1, "B", "cr cell1");
        send(CHAR_BS);
        m_col = 0;
        chk_cursor("bs");
        rd_check(0, 0, 8'h20, "bs cell0");
        rd_check(0, 1, "B", "bs cell1");
        send(CHAR_BS);
        chk_cursor("bs at col0");
        rd_check(0, 1, "B", "bs col0 cell1");

        // Line wrap at the last column.
        repeat (81) send("x");
        m_row = 1;
        m_col = 1;
        chk_cursor("wrap");
        for (int c = 0; c < COLS; c++) rd_check(0, c, "x", "wrap row0");
        rd_check(1, 0, "x", "wrap row1 col0");
        rd_check(1, 1, 8'h20, "wrap row1 col1");

        // Form feed clears everything.
        send(CHAR_FF);
        wait_ready(n);
        chk("ff clear length", 32'(n), 32'd2400);
        m_row = 0;
        m_col = 0;
        chk_cursor("ff");
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) rd_check(r, c, 8'h20, "ff blank");
        end

        // Fill every row, then scroll once from the bottom line.
        for (int r = 0; r < ROWS; r++) begin
            send(8'(8'h30 + r));
            send(8'(8'h30 + r));
            send(CHAR_LF);
            if (r < ROWS - 1) begin
                m_row = r + 1;
            end else begin
                wait_ready(n);
                chk("scroll length", 32'(n), 32'd80);
            end
        end
        m_row = ROWS - 1;
        m_col = 0;
        chk_cursor("scroll");
        for (int r = 0; r < ROWS - 1; r++) begin
            rd_check(r, 0, 8'(8'h31 + r), "scroll col0");
            rd_check(r, 1, 8'(8'h31 + r), "scroll col1");
            rd_check(r, 2, 8'h20, "scroll col2");
        end
        for (int c = 0; c < COLS; c++) rd_check(ROWS - 1, c, 8'h20, "scroll bottom");

        // Write through the wrapped top pointer, then read-before-write.
        send("Z");
        m_col = 1;
        rd_check(ROWS - 1, 0, "Z", "wrapped write");
        bus.rd_row = ROW_W'(ROWS - 1);
        bus.rd_col = COL_W'(1);
        e.data = 8'h20;
        e.hit  = hit_model(ROWS - 1, 1);
        exp_q.push_back(e);
        send("Q");
        e = exp_q.pop_front();
        chk("rbw rd_data", 32'(bus.rd_data), 32'(e.data));
        chk("rbw cursor_hit", 32'(bus.cursor_hit), 32'(e.hit));
        m_col = 2;
        rd_check(ROWS - 1, 1, "Q", "rbw after");

        // Out-of-range reads.
        rd_check(ROWS, 0, 8'h20, "oob row");
        rd_check(0, COLS, 8'h20, "oob col");
        rd_check(31, 127, 8'h20, "oob both");

        // Reset during a clear restarts it from cell 0.
        send(CHAR_FF);
        repeat (1000) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid-clear reset ready", 32'(bus.char_ready), 32'd0);
        rst = 1'b1;
        wait_ready(n);
        chk("restart clear length", 32'(n), 32'd2400);
        m_row = 0;
        m_col = 0;
        chk_cursor("restart");
        rd_check(0, 0, 8'h20, "restart cell0");
        rd_check(ROWS - 1, 0, 8'h20, "restart last row");

        // Cursor hit alignment at (3,5).
        repeat (3) send(CHAR_LF);
        repeat (5) send(" ");
        m_row = 3;
        m_col = 5;
        chk_cursor("hit setup");
        rd_check(3, 5, 8'h20, "hit on");
        rd_check(3, 6, 8'h20, "hit off");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
